// File: rtl/reglist_seq_encoder_pkg.sv
// Shared constants, FSM state type and popcount helper for the register-list encoder.
package reglist_pkg;

   localparam int unsigned NREGS = 16;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] vec);
      logic [CNT_W-1:0] cnt;
      cnt = {CNT_W{1'b0}};
      for (int i = 0; i < int'(NREGS); i++) begin
         cnt = cnt + CNT_W'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/reglist_seq_encoder_if.sv
// Mask-in / index-out handshake bundle; slave is the encoder's view, master the environment's.
interface reglist_seq_encoder_if;
   import reglist_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [NREGS-1:0] in_mask;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic [CNT_W-1:0] out_total;
   logic             done;

   modport slave (
      input  in_valid, in_mask, out_ready,
      output in_ready, out_valid, out_idx, out_last, out_total, done
   );

   modport master (
      output in_valid, in_mask, out_ready,
      input  in_ready, out_valid, out_idx, out_last, out_total, done
   );

endinterface

// File: rtl/reglist_seq_encoder_prio_enc.sv
// Priority encoder selecting the next register to emit; REGLIST_DESCEND_EN picks the
// highest set bit instead of the lowest.
module reglist_prio_enc
   import reglist_pkg::*;
(
   input  logic [NREGS-1:0] vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   logic [IDX_W-1:0] idx_s;
   logic             hit_s;

   // First-hit scan in emit order; later hits never override the first one.
   always_comb begin
      idx_s = {IDX_W{1'b0}};
      hit_s = 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
`ifdef REGLIST_DESCEND_EN
         idx_s = (vec_i[int'(NREGS) - 1 - i] && !hit_s) ? IDX_W'(int'(NREGS) - 1 - i) : idx_s;
         hit_s = hit_s | vec_i[int'(NREGS) - 1 - i];
`else
         idx_s = (vec_i[i] && !hit_s) ? IDX_W'(i) : idx_s;
         hit_s = hit_s | vec_i[i];
`endif
      end
   end

   assign idx_o   = idx_s;
   assign found_o = hit_s;

endmodule

// File: rtl/reglist_seq_encoder.sv
// Sequential register-list encoder: latches a register-select mask and emits one index
// per handshake. Emit order is set by REGLIST_DESCEND_EN inside reglist_prio_enc.
module reglist_seq_encoder
   import reglist_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   reglist_seq_encoder_if.slave  bus
);

   state_e           state_q,   state_d;
   logic [NREGS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] total_q,   total_d;
   logic             done_q,    done_d;

   logic [IDX_W-1:0] idx_s;
   logic             found_s;
   logic             emit_s;
   logic             last_s;
   logic [NREGS-1:0] sel_onehot_s;

   reglist_prio_enc u_prio_enc (
      .vec_i   (pending_q),
      .idx_o   (idx_s),
      .found_o (found_s)
   );

   assign emit_s       = (state_q == EMIT);
   assign last_s       = emit_s && (popcount(pending_q) == CNT_W'(1));
   assign sel_onehot_s = NREGS'(1) << idx_s;

   // Next-state, pending mask, popcount latch and done pulse.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      total_d   = total_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               pending_d = bus.in_mask;
               total_d   = popcount(bus.in_mask);
               if (bus.in_mask != {NREGS{1'b0}}) begin
                  state_d = EMIT;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               pending_d = pending_q & ~sel_onehot_s;
               if (last_s) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = EMIT;
               end
            end else begin
               pending_d = pending_q;
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = {NREGS{1'b0}};
         end
      endcase
   end

   // State registers; reset abandons any pending mask without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= {NREGS{1'b0}};
         total_q   <= {CNT_W{1'b0}};
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         total_q   <= total_d;
         done_q    <= done_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = emit_s && found_s;
   assign bus.out_idx   = idx_s;
   assign bus.out_last  = last_s;
   assign bus.out_total = total_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_reglist_seq_encoder.sv
// Randomised and directed bench for reglist_seq_encoder against a list-based reference model.
module tb_reglist_seq_encoder;
   import reglist_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   reglist_seq_encoder_if bus ();

   reglist_seq_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Emit order: list of set-bit indices, reversed for descending builds.
   function automatic void expected_order(input logic [15:0] mask, output int q[$]);
      q = {};
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) begin
`ifdef REGLIST_DESCEND_EN
            q.push_front(i);
`else
            q.push_back(i);
`endif
         end
      end
   endfunction

   task automatic run_mask(input logic [15:0] mask, input int first_stall, input bit rand_stall);
      int q[$];
      int n;
      int stall;
      expected_order(mask, q);
      n = q.size();
      check("accept_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_mask  = mask;
      step();
      bus.in_mask  = 16'($urandom);
      bus.in_valid = 1'($urandom_range(0, 1));
      if (n == 0) begin
         bus.in_valid = 1'b0;
         check("zero_out_valid", 32'(bus.out_valid), 32'd0);
         check("zero_done", 32'(bus.done), 32'd1);
         check("zero_in_ready", 32'(bus.in_ready), 32'd1);
         check("zero_total", 32'(bus.out_total), 32'd0);
         return;
      end
      for (int k = 0; k < n; k++) begin
         stall = (k == 0) ? first_stall : (rand_stall ? ($urandom_range(0, 3) == 0 ? 1 : 0) : 0);
         bus.out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_idx", 32'(bus.out_idx), 32'(q[k]));
            check("stall_last", 32'(bus.out_last), 32'(k == n - 1));
            bus.in_mask  = 16'($urandom);
            bus.in_valid = 1'b1;
            step();
         end
         bus.out_ready = 1'b1;
         check("emit_valid", 32'(bus.out_valid), 32'd1);
         check("emit_idx", 32'(bus.out_idx), 32'(q[k]));
         check("emit_last", 32'(bus.out_last), 32'(k == n - 1));
         check("emit_total", 32'(bus.out_total), 32'(n));
         check("emit_done_low", 32'(bus.done), 32'd0);
         check("emit_in_ready_low", 32'(bus.in_ready), 32'd0);
         step();
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("fin_done", 32'(bus.done), 32'd1);
      check("fin_out_valid", 32'(bus.out_valid), 32'd0);
      check("fin_in_ready", 32'(bus.in_ready), 32'd1);
      check("fin_total", 32'(bus.out_total), 32'(n));
   endtask

   initial begin
      logic [15:0] m;
      int q[$];
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_mask   = 16'h0000;
      bus.out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_idx", 32'(bus.out_idx), 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      check("rst_out_total", 32'(bus.out_total), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);

      run_mask(16'h8421, 0, 1'b0);
      step();
      run_mask(16'h0000, 0, 1'b0);
      step();
      check("zero_done_once", 32'(bus.done), 32'd0);
      check("zero_stays_ready", 32'(bus.in_ready), 32'd1);

      // Full mask, then a single-bit mask accepted in the done cycle.
      run_mask(16'hFFFF, 0, 1'b0);
      run_mask(16'h0002, 0, 1'b0);
      step();
      run_mask(16'h0030, 3, 1'b0);
      run_mask(16'h8000, 1, 1'b0);

      // Reset in the middle of a mask: no done, encoder back to idle.
      expected_order(16'h00F0, q);
      bus.in_valid  = 1'b1;
      bus.in_mask   = 16'h00F0;
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("mid_first_idx", 32'(bus.out_idx), 32'(q[0]));
      step();
      check("mid_second_idx", 32'(bus.out_idx), 32'(q[1]));
      step();
      bus.out_ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_done", 32'(bus.done), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      check("mid_rst_total", 32'(bus.out_total), 32'd0);
      step();
      check("mid_rst_no_done", 32'(bus.done), 32'd0);
      check("mid_rst_still_idle", 32'(bus.out_valid), 32'd0);

      for (int t = 0; t < 40; t++) begin
         m = 16'($urandom);
         if (t % 4 == 1) m = m & 16'($urandom);
         if (t % 8 == 3) m = 16'h0001 << $urandom_range(0, 15);
         if (t % 10 == 7) m = 16'h0000;
         run_mask(m, $urandom_range(0, 2), 1'b1);
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
